// File: rtl/sram_pkg.sv
// Shared types and helpers for the sram_bank memory slice.
// Holds the bank FSM state type, the latency limit and the byte-merge helper.
package sram_pkg;

    typedef enum logic {
        INIT = 1'b0,
        RUN  = 1'b1
    } sram_state_e;

    localparam int READ_LAT_MAX = 2;

    // Widest word be_merge handles; callers zero-extend and truncate.
    localparam int MERGE_W    = 512;
    localparam int MERGE_BE_W = MERGE_W / 8;

    function automatic logic [MERGE_W-1:0] be_merge(
        input logic [MERGE_W-1:0]    old_word,
        input logic [MERGE_W-1:0]    new_word,
        input logic [MERGE_BE_W-1:0] be
    );
        logic [MERGE_W-1:0] merged;
        merged = old_word;
        for (int b = 0; b < MERGE_BE_W; b++) begin
            if (be[b]) begin
                merged[8*b +: 8] = new_word[8*b +: 8];
            end
        end
        return merged;
    endfunction

endpackage

// File: rtl/sram_array.sv
// Plain single-port storage with byte-masked writes and a registered read port.
// Deliberately has no reset so the array maps onto block RAM.
module sram_array
    import sram_pkg::*;
#(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 32
) (
    input  logic                clk,
    input  logic                we,
    input  logic                re,
    input  logic [DATA_W/8-1:0] be,
    input  logic [ADDR_W-1:0]   addr,
    input  logic [DATA_W-1:0]   wdata,
    output logic [DATA_W-1:0]   rdata
);

    logic [DATA_W-1:0] mem [2**ADDR_W];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= DATA_W'(be_merge(MERGE_W'(mem[addr]), MERGE_W'(wdata), MERGE_BE_W'(be)));
        end
        if (re) begin
            rdata <= mem[addr];
        end
    end

endmodule

// File: rtl/sram_bank.sv
// Single-port word memory bank: valid/ready requests, byte strobes, 1 or 2 cycle
// read latency, and a post-reset clear engine that writes INIT_VALUE word by word.
module sram_bank
    import sram_pkg::*;
#(
    parameter int                ADDR_W     = 10,
    parameter int                DATA_W     = 32,
    parameter int                READ_LAT   = 1,
    parameter logic [DATA_W-1:0] INIT_VALUE = '0
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                req_valid_i,
    output logic                req_ready_o,
    input  logic                req_we_i,
    input  logic [DATA_W/8-1:0] req_be_i,
    input  logic [ADDR_W-1:0]   req_addr_i,
    input  logic [DATA_W-1:0]   req_wdata_i,
    output logic                rsp_valid_o,
    output logic [DATA_W-1:0]   rsp_rdata_o,
    output logic                init_busy_o,
    output sram_state_e         dbg_state_o
);

    if (READ_LAT < 1 || READ_LAT > READ_LAT_MAX) begin : g_bad_lat
        $error("sram_bank: READ_LAT must be 1 or 2");
    end
    if (DATA_W % 8 != 0 || DATA_W > MERGE_W) begin : g_bad_width
        $error("sram_bank: DATA_W must be a multiple of 8 and at most MERGE_W");
    end

    // Handshake: a request transfers on a rising edge where req_valid_i and
    // req_ready_o are both 1; ready depends on state only, never on valid.
    sram_state_e       state, state_next;
    logic [ADDR_W-1:0] init_cnt;
    logic              accept, rd_accept;
    logic              arr_we;
    logic [DATA_W/8-1:0] arr_be;
    logic [ADDR_W-1:0] arr_addr;
    logic [DATA_W-1:0] arr_wdata, arr_rdata;
    logic              rd_v1;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state    <= INIT;
            init_cnt <= '0;
        end else begin
            state <= state_next;
            if (state == INIT) begin
                init_cnt <= init_cnt + ADDR_W'(1);
            end
        end
    end

    always_comb begin
        state_next = state;
        if (state == INIT && init_cnt == '1) begin
            state_next = RUN;
        end
    end

    assign req_ready_o = (state == RUN);
    assign init_busy_o = (state == INIT);
    assign dbg_state_o = state;
    assign accept      = req_valid_i & req_ready_o;
    assign rd_accept   = accept & ~req_we_i;

    // The clear engine owns the array port while INIT; requests are refused then.
    always_comb begin
        arr_we    = accept & req_we_i;
        arr_be    = req_be_i;
        arr_addr  = req_addr_i;
        arr_wdata = req_wdata_i;
        if (state == INIT) begin
            arr_we    = 1'b1;
            arr_be    = '1;
            arr_addr  = init_cnt;
            arr_wdata = INIT_VALUE;
        end
    end

    sram_array #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_array (
        .clk   (clk_i),
        .we    (arr_we),
        .re    (rd_accept),
        .be    (arr_be),
        .addr  (arr_addr),
        .wdata (arr_wdata),
        .rdata (arr_rdata)
    );

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rd_v1 <= 1'b0;
        end else begin
            rd_v1 <= rd_accept;
        end
    end

    if (READ_LAT == 1) begin : g_lat1
        // The array register only loads on reads, so it already holds between
        // responses; rd_seen masks stale contents until the first read after reset.
        logic rd_seen;

        always_ff @(posedge clk_i or posedge rst_i) begin
            if (rst_i) begin
                rd_seen <= 1'b0;
            end else if (rd_accept) begin
                rd_seen <= 1'b1;
            end
        end

        assign rsp_valid_o = rd_v1;
        assign rsp_rdata_o = rd_seen ? arr_rdata : '0;
    end else begin : g_lat2
        logic              rd_v2;
        logic [DATA_W-1:0] rdata_q;

        always_ff @(posedge clk_i or posedge rst_i) begin
            if (rst_i) begin
                rd_v2   <= 1'b0;
                rdata_q <= '0;
            end else begin
                rd_v2 <= rd_v1;
                if (rd_v1) begin
                    rdata_q <= arr_rdata;
                end
            end
        end

        assign rsp_valid_o = rd_v2;
        assign rsp_rdata_o = rdata_q;
    end

endmodule

// File: tb/tb_sram_bank.sv
// Bench for sram_bank: a READ_LAT=1 and a READ_LAT=2 bank share one request stream
// and are compared against a word-array model with timed response queues.
module tb_sram_bank;
  import sram_pkg::*;

  localparam int AW    = 10;
  localparam int DW    = 32;
  localparam int DEPTH = 1 << AW;

  logic          clk = 1'b0;
  logic          rst;
  logic          req_valid;
  logic          req_we;
  logic [3:0]    req_be;
  logic [AW-1:0] req_addr;
  logic [DW-1:0] req_wdata;

  logic          ready1, ready2, rsp_v1, rsp_v2, busy1, busy2;
  logic [DW-1:0] rdata1, rdata2;
  sram_state_e   st1, st2;

  sram_bank #(.ADDR_W(AW), .DATA_W(DW), .READ_LAT(1), .INIT_VALUE('0)) dut1 (
    .clk_i(clk), .rst_i(rst), .req_valid_i(req_valid), .req_ready_o(ready1),
    .req_we_i(req_we), .req_be_i(req_be), .req_addr_i(req_addr), .req_wdata_i(req_wdata),
    .rsp_valid_o(rsp_v1), .rsp_rdata_o(rdata1), .init_busy_o(busy1), .dbg_state_o(st1)
  );

  sram_bank #(.ADDR_W(AW), .DATA_W(DW), .READ_LAT(2), .INIT_VALUE('0)) dut2 (
    .clk_i(clk), .rst_i(rst), .req_valid_i(req_valid), .req_ready_o(ready2),
    .req_we_i(req_we), .req_be_i(req_be), .req_addr_i(req_addr), .req_wdata_i(req_wdata),
    .rsp_valid_o(rsp_v2), .rsp_rdata_o(rdata2), .init_busy_o(busy2), .dbg_state_o(st2)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- scoreboard ----------------
  int total = 0;
  int bad   = 0;
  logic [DW-1:0] model_mem [DEPTH];
  logic [DW-1:0] exp_q1[$];
  logic [DW-1:0] exp_q2[$];
  int            due_q1[$];
  int            due_q2[$];
  logic [DW-1:0] last1, last2;
  bit            mon_on = 1'b0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h expected=%h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic model_clear();
    for (int i = 0; i < DEPTH; i++) model_mem[i] = '0;
    exp_q1.delete();
    exp_q2.delete();
    due_q1.delete();
    due_q2.delete();
    last1 = '0;
    last2 = '0;
  endtask

  always @(negedge clk) begin
    if (mon_on) begin
      if (rsp_v1) begin
        if (exp_q1.size() == 0) check("spurious_rsp_l1", 32'(rsp_v1), 32'd0);
        else begin
          last1 = exp_q1.pop_front();
          check("rdata_l1", rdata1, last1);
          check("rsp_time_l1", 32'(cyc), 32'(due_q1.pop_front()));
        end
      end else begin
        check("rdata_hold_l1", rdata1, last1);
        if (due_q1.size() > 0 && due_q1[0] <= cyc) begin
          check("missing_rsp_l1", 32'(rsp_v1), 32'd1);
          void'(exp_q1.pop_front());
          void'(due_q1.pop_front());
        end
      end
      if (rsp_v2) begin
        if (exp_q2.size() == 0) check("spurious_rsp_l2", 32'(rsp_v2), 32'd0);
        else begin
          last2 = exp_q2.pop_front();
          check("rdata_l2", rdata2, last2);
          check("rsp_time_l2", 32'(cyc), 32'(due_q2.pop_front()));
        end
      end else begin
        check("rdata_hold_l2", rdata2, last2);
        if (due_q2.size() > 0 && due_q2[0] <= cyc) begin
          check("missing_rsp_l2", 32'(rsp_v2), 32'd1);
          void'(exp_q2.pop_front());
          void'(due_q2.pop_front());
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic idle(input int n);
    req_valid = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  // One request, accepted on the next rising edge; returns at edge+1.
  task automatic do_req(input logic we, input logic [3:0] be, input logic [AW-1:0] addr,
                        input logic [DW-1:0] wd);
    req_valid = 1'b1;
    req_we    = we;
    req_be    = be;
    req_addr  = addr;
    req_wdata = wd;
    check("ready_l1", 32'(ready1), 32'd1);
    check("ready_l2", 32'(ready2), 32'd1);
    @(posedge clk);
    #1;
    if (we) begin
      for (int b = 0; b < 4; b++)
        if (be[b]) model_mem[addr][8*b +: 8] = wd[8*b +: 8];
    end else begin
      exp_q1.push_back(model_mem[addr]);
      due_q1.push_back(cyc);
      exp_q2.push_back(model_mem[addr]);
      due_q2.push_back(cyc + 1);
    end
    req_valid = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_ready"}, {30'd0, ready1, ready2}, 32'd0);
    check({tag, "_rsp_valid"}, {30'd0, rsp_v1, rsp_v2}, 32'd0);
    check({tag, "_rdata_l1"}, rdata1, 32'd0);
    check({tag, "_rdata_l2"}, rdata2, 32'd0);
    check({tag, "_busy"}, {30'd0, busy1, busy2}, 32'd3);
    check({tag, "_state"}, {30'd0, st1, st2}, {30'd0, INIT, INIT});
  endtask

  // Hold reset for a few cycles, then release just after a falling edge.
  task automatic do_reset(input string tag);
    rst       = 1'b1;
    req_valid = 1'b0;
    model_clear();
    repeat (3) @(negedge clk);
    check_reset_outputs(tag);
    rst = 1'b0;
  endtask

  task automatic wait_init(input string tag);
    int n = 0;
    while (!ready1 && n < 3000) begin
      check({tag, "_busy_in_init"}, {30'd0, busy1, busy2}, 32'd3);
      @(posedge clk);
      #1;
      n++;
    end
    check({tag, "_len"}, 32'(n), 32'(DEPTH));
    check({tag, "_done_busy"}, {30'd0, busy1, busy2}, 32'd0);
    check({tag, "_done_state"}, {30'd0, st1, st2}, {30'd0, RUN, RUN});
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rst = 1'b1;
    req_valid = 1'b0;
    req_we = 1'b0;
    req_be = '0;
    req_addr = '0;
    req_wdata = '0;
    #1;
    mon_on = 1'b1;

    // Requests held during INIT must be ignored.
    do_reset("rst0");
    req_valid = 1'b1;
    req_we    = 1'b1;
    req_be    = 4'hF;
    req_addr  = '0;
    req_wdata = 32'hFFFF_FFFF;
    wait_init("init0");
    req_valid = 1'b0;
    do_req(1'b0, 4'h0, 10'd0, '0);
    do_req(1'b0, 4'h0, 10'd5, '0);
    idle(3);

    // Byte-strobe merge.
    do_req(1'b1, 4'hF, 10'd3, 32'hDEAD_BEEF);
    do_req(1'b1, 4'h2, 10'd3, 32'h0000_AA00);
    do_req(1'b0, 4'h0, 10'd3, '0);
    idle(3);

    // Read directly after write to the same word.
    do_req(1'b1, 4'hF, 10'd7, 32'h1234_5678);
    do_req(1'b0, 4'h0, 10'd7, '0);
    idle(3);

    // Back-to-back pipelined reads.
    for (int i = 0; i < 3; i++) do_req(1'b1, 4'hF, AW'(i), 32'h10 + 32'(i));
    for (int i = 0; i < 3; i++) do_req(1'b0, 4'h0, AW'(i), '0);
    idle(4);

    // Random traffic over a small window so reads hit written words.
    for (int i = 0; i < 400; i++) begin
      do_req(1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)),
             AW'($urandom_range(0, 15)), $urandom);
      if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 2));
    end
    idle(4);

    // Reset in RUN with a read in flight: responses vanish at once.
    do_req(1'b0, 4'h0, 10'd3, '0);
    rst = 1'b1;
    #1;
    check("run_rst_rsp_valid", {30'd0, rsp_v1, rsp_v2}, 32'd0);
    do_reset("rst_run");
    wait_init("init_run");
    do_req(1'b0, 4'h0, 10'd3, '0);
    do_req(1'b0, 4'h0, 10'd7, '0);
    idle(3);

    // Reset part way through the clear restarts it from address 0.
    do_req(1'b1, 4'hF, 10'd9, 32'hCAFE_F00D);
    idle(1);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    model_clear();
    repeat (500) @(posedge clk);
    #1;
    do_reset("rst_mid_init");
    wait_init("init_mid");
    do_req(1'b0, 4'h0, 10'd9, '0);
    do_req(1'b0, 4'h0, 10'd1, '0);
    idle(5);

    check("drain_l1", 32'(exp_q1.size()), 32'd0);
    check("drain_l2", 32'(exp_q2.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

endmodule
